// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side valid/ready bundle plus the fifo write port shared by fifo_wr_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives requests and the fifo.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_ready;

  modport slave (
    input  req_valid, req_data, fifo_wr_ready,
    output req_ready, fifo_wr_en, fifo_wr_data
  );

  modport master (
    output req_valid, req_data, fifo_wr_ready,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ requesters, with optional burst lock.
// Define FIFO_ARB_STATS_EN to add per-requester saturating transfer counters (stat_clr / stat_cnt).
module fifo_wr_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 8,
  parameter int  BURST_LEN  = 4,
  parameter int  CNT_WIDTH  = 16,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int BEAT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  fifo_wr_arbiter_if.slave  bus,
  output logic [IDX_W-1:0]  owner,
  output logic              busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  stat_cnt
`endif
);

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt, owner_nxt;
  logic [BEAT_W-1:0]     beat_cnt, beat_cnt_nxt;
  logic [IDX_W-1:0]      cand;
  logic                  cand_vld;
  logic [NUM_REQ-1:0]    gnt;
  logic [DATA_WIDTH-1:0] wr_data;

  if (NUM_REQ < 2 || BURST_LEN < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: NUM_REQ must be >= 2 and BURST_LEN >= 1");
  end

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Index arithmetic is done in int so non-power-of-2 NUM_REQ wraps correctly.
  always_comb begin : p_cand
    int idx;
    cand     = '0;
    cand_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!cand_vld && bus.req_valid[IDX_W'(idx)]) begin
        cand_vld = 1'b1;
        cand     = IDX_W'(idx);
      end
    end
  end

  // Grants are forced off while reset is held so no word slips through during an async reset.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    gnt          = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (cand_vld && bus.fifo_wr_ready) begin
            gnt[cand] = 1'b1;
            owner_nxt = cand;
            if (BURST_LEN == 1) begin
              rr_ptr_nxt = wrap_inc(cand);
            end else begin
              state_nxt    = BURST;
              beat_cnt_nxt = BEAT_W'(1);
            end
          end
        end
        BURST: begin
          if (!bus.req_valid[owner]) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = wrap_inc(owner);
          end else if (bus.fifo_wr_ready) begin
            gnt[owner]   = 1'b1;
            beat_cnt_nxt = beat_cnt + 1'b1;
            if (int'(beat_cnt) + 1 == BURST_LEN) begin
              state_nxt  = IDLE;
              rr_ptr_nxt = wrap_inc(owner);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) wr_data = wr_data | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.req_ready    = gnt;
  assign bus.fifo_wr_en   = |gnt;
  assign bus.fifo_wr_data = wr_data;
  assign busy             = (state == BURST);

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [CNT_WIDTH-1:0] cnt;
    // Clear has priority over a same-cycle transfer; counts stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (stat_clr) begin
        cnt <= '0;
      end else if (gnt[i] && (cnt != {CNT_WIDTH{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign stat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`else
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("fifo_wr_arbiter: CNT_WIDTH must be >= 1");
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one per-word (BURST_LEN=1) and one burst (BURST_LEN=4) instance.
// The stats scenario runs only when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  logic [1:0] owner_rr, owner_bl;
  logic       busy_rr, busy_bl;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus_rr ();
  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus_bl ();

`ifdef FIFO_ARB_STATS_EN
  logic       stat_clr = 1'b0;
  logic [7:0] stat_cnt_rr, stat_cnt_bl;
`endif

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(2)) u_rr (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_rr),
    .owner    (owner_rr),
    .busy     (busy_rr)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt_rr)
`endif
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(2)) u_bl (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_bl),
    .owner    (owner_bl),
    .busy     (busy_bl)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt_bl)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    reset = 1'b1;
    bus_rr.req_valid = '0;
    bus_bl.req_valid = '0;
    bus_rr.fifo_wr_ready = 1'b1;
    bus_bl.fifo_wr_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    bus_rr.req_valid = 4'b1111;
    bus_bl.req_valid = 4'b1111;
    #1;
    compared++;
    if (bus_bl.req_ready !== 4'b0001) begin
      mismatched++; $display("FAIL reset_pre_grant: got %b want 0001", bus_bl.req_ready);
    end
    @(negedge clk);
    #1;
    compared++;
    if (busy_bl !== 1'b1) begin
      mismatched++; $display("FAIL reset_pre_busy: got %b want 1", busy_bl);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (bus_bl.req_ready !== 4'b0000 || bus_rr.req_ready !== 4'b0000) begin
      mismatched++; $display("FAIL reset_ready: got %b/%b want 0000/0000", bus_bl.req_ready, bus_rr.req_ready);
    end
    compared++;
    if (bus_bl.fifo_wr_en !== 1'b0 || bus_bl.fifo_wr_data !== 8'h00) begin
      mismatched++; $display("FAIL reset_wr: got en=%b data=%h want en=0 data=00", bus_bl.fifo_wr_en, bus_bl.fifo_wr_data);
    end
    compared++;
    if (busy_bl !== 1'b0) begin
      mismatched++; $display("FAIL reset_busy: got %b want 0", busy_bl);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    compared++;
    if (bus_bl.req_ready !== 4'b0001 || bus_rr.req_ready !== 4'b0001) begin
      mismatched++; $display("FAIL reset_first_grant: got %b/%b want 0001/0001", bus_bl.req_ready, bus_rr.req_ready);
    end
    compared++;
    if (owner_bl !== 2'd0 || busy_bl !== 1'b0) begin
      mismatched++; $display("FAIL reset_owner: got owner=%0d busy=%b want 0/0", owner_bl, busy_bl);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    logic [7:0] exp_dat;
    do_reset();
    bus_rr.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      exp_dat = 8'hA0 + 8'(k % 4);
      #1;
      compared++;
      if (bus_rr.req_ready !== exp_rdy || bus_rr.fifo_wr_en !== 1'b1) begin
        mismatched++; $display("FAIL rr_grant[%0d]: got %b en=%b want %b en=1", k, bus_rr.req_ready, bus_rr.fifo_wr_en, exp_rdy);
      end
      compared++;
      if (bus_rr.fifo_wr_data !== exp_dat) begin
        mismatched++; $display("FAIL rr_data[%0d]: got %h want %h", k, bus_rr.fifo_wr_data, exp_dat);
      end
      @(negedge clk);
    end
    bus_rr.req_valid = '0;
  endtask

  task automatic test_burst;
    logic [3:0] exp_rdy [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    logic       exp_busy [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    bus_bl.req_valid = 4'b0011;
    for (int c = 0; c < 9; c++) begin
      #1;
      compared++;
      if (bus_bl.req_ready !== exp_rdy[c] || busy_bl !== exp_busy[c]) begin
        mismatched++; $display("FAIL burst[%0d]: got rdy=%b busy=%b want rdy=%b busy=%b", c, bus_bl.req_ready, busy_bl, exp_rdy[c], exp_busy[c]);
      end
      if (c == 5) begin
        compared++;
        if (owner_bl !== 2'd1) begin
          mismatched++; $display("FAIL burst_owner: got %0d want 1", owner_bl);
        end
      end
      @(negedge clk);
    end
    bus_bl.req_valid = '0;
  endtask

  task automatic test_drop;
    do_reset();
    bus_bl.req_valid = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      #1;
      compared++;
      if (bus_bl.req_ready !== 4'b0100 || bus_bl.fifo_wr_data !== 8'hA2) begin
        mismatched++; $display("FAIL drop_word[%0d]: got rdy=%b data=%h want 0100/a2", c, bus_bl.req_ready, bus_bl.fifo_wr_data);
      end
      @(negedge clk);
    end
    bus_bl.req_valid = 4'b1001;
    #1;
    compared++;
    if (bus_bl.req_ready !== 4'b0000 || bus_bl.fifo_wr_en !== 1'b0 || busy_bl !== 1'b1) begin
      mismatched++; $display("FAIL drop_bubble: got rdy=%b en=%b busy=%b want 0000/0/1", bus_bl.req_ready, bus_bl.fifo_wr_en, busy_bl);
    end
    @(negedge clk);
    #1;
    compared++;
    if (bus_bl.req_ready !== 4'b1000 || bus_bl.fifo_wr_data !== 8'hA3 || busy_bl !== 1'b0) begin
      mismatched++; $display("FAIL drop_next: got rdy=%b data=%h busy=%b want 1000/a3/0", bus_bl.req_ready, bus_bl.fifo_wr_data, busy_bl);
    end
    @(negedge clk);
    bus_bl.req_valid = '0;
  endtask

  task automatic test_stall;
    int words = 0;
    do_reset();
    bus_bl.req_valid = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      bus_bl.fifo_wr_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      #1;
      if (bus_bl.fifo_wr_en === 1'b1) words++;
      if (c >= 2 && c <= 4) begin
        compared++;
        if (bus_bl.req_ready !== 4'b0000 || bus_bl.fifo_wr_en !== 1'b0 || bus_bl.fifo_wr_data !== 8'h00) begin
          mismatched++; $display("FAIL stall_out[%0d]: got rdy=%b en=%b data=%h want 0000/0/00", c, bus_bl.req_ready, bus_bl.fifo_wr_en, bus_bl.fifo_wr_data);
        end
        compared++;
        if (owner_bl !== 2'd0 || busy_bl !== 1'b1) begin
          mismatched++; $display("FAIL stall_lock[%0d]: got owner=%0d busy=%b want 0/1", c, owner_bl, busy_bl);
        end
      end
      @(negedge clk);
    end
    compared++;
    if (words !== 4) begin
      mismatched++; $display("FAIL stall_words: got %0d want 4", words);
    end
    #1;
    compared++;
    if (busy_bl !== 1'b0 || bus_bl.req_ready !== 4'b0001) begin
      mismatched++; $display("FAIL stall_after: got busy=%b rdy=%b want 0/0001", busy_bl, bus_bl.req_ready);
    end
    @(negedge clk);
    bus_bl.req_valid = '0;
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats;
    do_reset();
    bus_rr.req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) @(negedge clk);
    bus_rr.req_valid = '0;
    #1;
    compared++;
    if (stat_cnt_rr !== 8'b0000_1100) begin
      mismatched++; $display("FAIL stats_sat: got %b want 00001100", stat_cnt_rr);
    end
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    compared++;
    if (stat_cnt_rr !== 8'h00) begin
      mismatched++; $display("FAIL stats_clr: got %b want 00000000", stat_cnt_rr);
    end
  endtask
`endif

  initial begin
    bus_rr.req_valid = '0;
    bus_bl.req_valid = '0;
    bus_rr.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus_bl.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus_rr.fifo_wr_ready = 1'b1;
    bus_bl.fifo_wr_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_burst();
    test_drop();
    test_stall();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
